// File: rtl/cmp_seq_arbiter.sv
// Shared multi-cycle magnitude comparator serving two requesters (ALU = 0,
// branch unit = 1). A round-robin arbiter picks one operation in IDLE, the
// operands are captured, and the engine scans CHUNK bits per cycle starting
// at the most significant chunk. The first differing chunk decides the
// result. The result is held on a valid/ready response port until taken.

module cmp_seq_arbiter #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_signed,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_signed,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_lt,
  output logic             rsp_eq,
  output logic             rsp_id,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             id_q, id_d;
  logic [KW-1:0]    k_q, k_d;
  logic             rsp_lt_q, rsp_lt_d;
  logic             rsp_eq_q, rsp_eq_d;

  logic             grant_valid_s;
  logic             grant_id_s;
  logic             handshake_s;
  logic [WIDTH-1:0] sel_a_s;
  logic [WIDTH-1:0] sel_b_s;
  logic             sel_signed_s;

  // Captured operands viewed as an array of chunks; index NCHUNK-1 is the MSB chunk.
  logic [NCHUNK-1:0][CHUNK-1:0] a_chunks_s;
  logic [NCHUNK-1:0][CHUNK-1:0] b_chunks_s;
  logic [KW-1:0]                chunk_idx_s;
  logic [CHUNK-1:0]             a_chunk_s;
  logic [CHUNK-1:0]             b_chunk_s;

  assign a_chunks_s = a_q;
  assign b_chunks_s = b_q;

  // Round-robin grant: priority only matters when both requesters are valid.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_id_s    = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_valid_s = 1'b1;
      grant_id_s    = prio_q;
    end else if (req1_valid) begin
      grant_valid_s = 1'b1;
      grant_id_s    = 1'b1;
    end else if (req0_valid) begin
      grant_valid_s = 1'b1;
      grant_id_s    = 1'b0;
    end else begin
      grant_valid_s = 1'b0;
      grant_id_s    = 1'b0;
    end
  end

  // Readies are offered only in IDLE and are held low while reset is asserted.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (rst_n && (state_q == ST_IDLE) && grant_valid_s) begin
      req0_ready = ~grant_id_s;
      req1_ready = grant_id_s;
    end else begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
    end
  end

  assign handshake_s = req0_ready | req1_ready;

  // Operand mux for the granted requester.
  always_comb begin
    sel_a_s      = req0_a;
    sel_b_s      = req0_b;
    sel_signed_s = req0_signed;
    if (grant_id_s) begin
      sel_a_s      = req1_a;
      sel_b_s      = req1_b;
      sel_signed_s = req1_signed;
    end else begin
      sel_a_s      = req0_a;
      sel_b_s      = req0_b;
      sel_signed_s = req0_signed;
    end
  end

  // Chunk under test: k counts from the MSB chunk downwards.
  always_comb begin
    chunk_idx_s = K_LAST - k_q;
    a_chunk_s   = a_chunks_s[chunk_idx_s];
    b_chunk_s   = b_chunks_s[chunk_idx_s];
  end

  // Next-state logic for the IDLE/RUN/DONE sequencer and its datapath.
  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    a_d      = a_q;
    b_d      = b_q;
    id_d     = id_q;
    k_d      = k_q;
    rsp_lt_d = rsp_lt_q;
    rsp_eq_d = rsp_eq_q;
    case (state_q)
      ST_IDLE: begin
        if (handshake_s) begin
          // Flipping both sign bits maps two's-complement order onto unsigned order.
          a_d     = {sel_a_s[WIDTH-1] ^ sel_signed_s, sel_a_s[WIDTH-2:0]};
          b_d     = {sel_b_s[WIDTH-1] ^ sel_signed_s, sel_b_s[WIDTH-2:0]};
          id_d    = grant_id_s;
          k_d     = '0;
          prio_d  = ~grant_id_s;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (a_chunk_s != b_chunk_s) begin
          rsp_lt_d = (a_chunk_s < b_chunk_s);
          rsp_eq_d = 1'b0;
          state_d  = ST_DONE;
        end else if (k_q == K_LAST) begin
          rsp_lt_d = 1'b0;
          rsp_eq_d = 1'b1;
          state_d  = ST_DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, operand and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      prio_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= 1'b0;
      k_q      <= '0;
      rsp_lt_q <= 1'b0;
      rsp_eq_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      a_q      <= a_d;
      b_q      <= b_d;
      id_q     <= id_d;
      k_q      <= k_d;
      rsp_lt_q <= rsp_lt_d;
      rsp_eq_q <= rsp_eq_d;
    end
  end

  assign rsp_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_lt    = rsp_lt_q;
  assign rsp_eq    = rsp_eq_q;
  assign rsp_id    = id_q;

  cmp_seq_arbiter_chk u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_lt     (rsp_lt),
    .rsp_eq     (rsp_eq),
    .rsp_id     (rsp_id),
    .busy       (busy)
  );

endmodule

// Protocol properties of the comparator's external interface.
module cmp_seq_arbiter_chk (
  input logic clk,
  input logic rst_n,
  input logic req0_ready,
  input logic req1_ready,
  input logic rsp_valid,
  input logic rsp_ready,
  input logic rsp_lt,
  input logic rsp_eq,
  input logic rsp_id,
  input logic busy
);

  a_one_grant: assert property (@(posedge clk) disable iff (!rst_n)
    !(req0_ready && req1_ready));

  a_grant_when_idle: assert property (@(posedge clk) disable iff (!rst_n)
    (req0_ready || req1_ready) |-> !busy);

  a_lt_eq_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    rsp_valid |-> !(rsp_lt && rsp_eq));

  a_rsp_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (rsp_valid && !rsp_ready) |=>
      (rsp_valid && $stable(rsp_lt) && $stable(rsp_eq) && $stable(rsp_id)));

endmodule

// File: tb/tb_cmp_seq_arbiter.sv
// Directed bench for cmp_seq_arbiter (WIDTH=64, CHUNK=8).
module tb_cmp_seq_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_signed;
  logic [63:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_signed;
  logic [63:0] req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_lt, rsp_eq, rsp_id, busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  cmp_seq_arbiter #(.WIDTH(64), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_signed(req0_signed),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_signed(req1_signed),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_lt(rsp_lt),
    .rsp_eq(rsp_eq), .rsp_id(rsp_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an operation and wait (bounded) for its handshake edge.
  task automatic issue(input logic id, input logic [63:0] a, input logic [63:0] b,
                       input logic sgn, output bit ok);
    ok = 1'b0;
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_signed = sgn;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_signed = sgn;
    end
    #1;
    for (int n = 0; n < 20; n++) begin
      if (id ? req1_ready : req0_ready) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    // Operands change after the handshake; the engine must ignore this.
    if (id) begin
      req1_valid = 1'b0; req1_a = 64'hDEAD_BEEF_0123_4567; req1_b = 64'h0; req1_signed = ~sgn;
    end else begin
      req0_valid = 1'b0; req0_a = 64'hDEAD_BEEF_0123_4567; req0_b = 64'h0; req0_signed = ~sgn;
    end
  endtask

  // Count edges from the handshake until rsp_valid is seen.
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  // Run one operation end-to-end and check latency and result fields.
  task automatic run_op(input string name, input logic id, input logic [63:0] a,
                        input logic [63:0] b, input logic sgn, input int exp_lat,
                        input logic exp_lt, input logic exp_eq);
    bit ok;
    int lat;
    issue(id, a, b, sgn, ok);
    total_cnt++; if (ok !== 1'b1) $display("FAIL %s_handshake: no handshake", name); else pass_cnt++;
    wait_rsp(lat);
    total_cnt++; if (lat != exp_lat) $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_lat); else pass_cnt++;
    total_cnt++;
    if ({rsp_lt, rsp_eq, rsp_id} !== {exp_lt, exp_eq, id})
      $display("FAIL %s_result: got lt=%b eq=%b id=%b want lt=%b eq=%b id=%b",
               name, rsp_lt, rsp_eq, rsp_id, exp_lt, exp_eq, id);
    else pass_cnt++;
    consume();
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = '0; req0_b = '0; req0_signed = 1'b0;
    req1_a = '0; req1_b = '0; req1_signed = 1'b0;
    rsp_ready = 1'b0;
    #3;
    total_cnt++;
    if ({req0_ready, req1_ready, rsp_valid, busy, rsp_lt, rsp_eq, rsp_id} !== 7'b0)
      $display("FAIL reset_outputs: got %b want 0000000",
               {req0_ready, req1_ready, rsp_valid, busy, rsp_lt, rsp_eq, rsp_id});
    else pass_cnt++;
    tick();
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
    total_cnt++;
    if ({req0_ready, req1_ready, busy} !== 3'b0)
      $display("FAIL reset_idle: got %b want 000", {req0_ready, req1_ready, busy});
    else pass_cnt++;
  endtask

  task automatic test_basic();
    run_op("t1_5_lt_10", 1'b0, 64'd5, 64'd10, 1'b0, 8, 1'b1, 1'b0);
  endtask

  task automatic test_signed();
    run_op("t2_unsigned", 1'b1, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1, 1'b0, 1'b0);
    run_op("t2_signed",   1'b0, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1, 1'b1, 1'b0);
  endtask

  task automatic test_equal();
    run_op("t3_eq25",  1'b0, 64'd25, 64'd25, 1'b0, 8, 1'b0, 1'b1);
    run_op("t3_eq0",   1'b1, 64'd0,  64'd0,  1'b1, 8, 1'b0, 1'b1);
    run_op("t3_allff", 1'b0, 64'd12345, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1, 1'b1, 1'b0);
  endtask

  task automatic test_round_robin();
    int cnt;
    logic exp_id;
    pulse_reset();
    req0_a = 64'd1; req0_b = 64'd2; req0_signed = 1'b0;
    req1_a = 64'd2; req1_b = 64'd1; req1_signed = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_id = (i % 2 == 1) || (i == 4);
      cnt = 0;
      while (!rsp_valid && cnt < 40) begin
        tick();
        cnt++;
      end
      total_cnt++;
      if ({rsp_valid, rsp_id, rsp_lt} !== {1'b1, exp_id, ~exp_id})
        $display("FAIL t4_grant%0d: got valid=%b id=%b lt=%b want valid=1 id=%b lt=%b",
                 i, rsp_valid, rsp_id, rsp_lt, exp_id, ~exp_id);
      else pass_cnt++;
      if (i == 3) req0_valid = 1'b0;
      if (i == 4) req1_valid = 1'b0;
      tick();
    end
    rsp_ready = 1'b0;
    tick();
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL t4_idle: got busy=%b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_stall();
    bit ok;
    int lat;
    issue(1'b0, 64'd1, 64'd0, 1'b0, ok);
    req1_valid = 1'b1; req1_a = 64'd0; req1_b = 64'd1; req1_signed = 1'b0;
    total_cnt++; if (ok !== 1'b1) $display("FAIL t5_hs0: no handshake"); else pass_cnt++;
    wait_rsp(lat);
    total_cnt++; if (lat != 8) $display("FAIL t5_latency0: got %0d want 8", lat); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if ({rsp_valid, rsp_lt, rsp_eq, rsp_id, req1_ready} !== 5'b10000)
        $display("FAIL t5_stall%0d: got %b want 10000", i,
                 {rsp_valid, rsp_lt, rsp_eq, rsp_id, req1_ready});
      else pass_cnt++;
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    total_cnt++;
    if ({rsp_valid, req1_ready} !== 2'b01)
      $display("FAIL t5_idle_grant: got valid=%b req1_ready=%b want 0 1", rsp_valid, req1_ready);
    else pass_cnt++;
    tick();
    req1_valid = 1'b0;
    total_cnt++; if (busy !== 1'b1) $display("FAIL t5_busy: got %b want 1", busy); else pass_cnt++;
    wait_rsp(lat);
    total_cnt++; if (lat != 8) $display("FAIL t5_latency1: got %0d want 8", lat); else pass_cnt++;
    total_cnt++;
    if ({rsp_lt, rsp_eq, rsp_id} !== 3'b101)
      $display("FAIL t5_result1: got %b want 101", {rsp_lt, rsp_eq, rsp_id});
    else pass_cnt++;
    consume();
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    bit seen;
    issue(1'b0, 64'd1, 64'd2, 1'b0, ok);
    total_cnt++; if (ok !== 1'b1) $display("FAIL t6_hs: no handshake"); else pass_cnt++;
    tick(); tick(); tick();
    total_cnt++; if (busy !== 1'b1) $display("FAIL t6_running: got busy=%b want 1", busy); else pass_cnt++;
    req1_valid = 1'b1; req1_a = 64'd7; req1_b = 64'd9; req1_signed = 1'b0;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({rsp_valid, busy, req0_ready, req1_ready} !== 4'b0000)
      $display("FAIL t6_async_reset: got %b want 0000", {rsp_valid, busy, req0_ready, req1_ready});
    else pass_cnt++;
    tick();
    total_cnt++; if (req1_ready !== 1'b0) $display("FAIL t6_ready_in_reset: got %b want 0", req1_ready); else pass_cnt++;
    req1_valid = 1'b0;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (rsp_valid || busy) seen = 1'b1;
    end
    total_cnt++; if (seen !== 1'b0) $display("FAIL t6_discard: got activity=%b want 0", seen); else pass_cnt++;
    run_op("t6_after", 1'b0, 64'h0000_0000_FFFF_FFFF, 64'h0000_0001_0000_0000, 1'b0, 4, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_equal();
    test_round_robin();
    test_stall();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
